trion_sdp_bram: RTL and testbench

TRION_SDP_BRAM -- requirements
Module: TrionSDPBRAM

---
 rtl/trion_sdp_bram.sv | 70 +++++++
 tb/tb_trion_sdp_bram.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/trion_sdp_bram.sv
// Simple dual-port block RAM: one write port and one read-first read port on a shared clock,
// with an optional second output register stage.
module trion_sdp_bram #(
    parameter int    pDataWidth = 8,
    parameter int    pAddrWidth = 9,
    parameter string pOutReg    = "no"
) (
    input  logic                  iCLK,
    input  logic                  inARST,
    input  logic [pDataWidth-1:0] iWd,
    input  logic [pAddrWidth-1:0] iWa,
    input  logic                  iWe,
    input  logic [pAddrWidth-1:0] iRa,
    input  logic                  iRe,
    output logic [pDataWidth-1:0] oRd
);

    localparam int cDepth = 1 << pAddrWidth;

    generate
        if (!(pDataWidth == 1 || pDataWidth == 2 || pDataWidth == 4 ||
              pDataWidth == 8 || pDataWidth == 16)) begin : gBadWidth
            $error("trion_sdp_bram: pDataWidth=%0d unsupported (use 1, 2, 4, 8 or 16)", pDataWidth);
        end
    endgenerate

    // Zero power-up image; the array itself carries no reset so it maps onto a block RAM.
    logic [pDataWidth-1:0] mem [cDepth] = '{default: '0};
    logic [pDataWidth-1:0] rdStage1;

    always_ff @(posedge iCLK) begin
        if (inARST && iWe) begin
            mem[iWa] <= iWd;
        end
    end

    // Read-first: a same-edge write to iRa is not seen until the next read.
    always_ff @(posedge iCLK) begin
        if (!inARST) begin
            rdStage1 <= '0;
        end else if (iRe) begin
            rdStage1 <= mem[iRa];
        end
    end

    generate
        if (pOutReg == "yes") begin : gOutReg
            logic                  reDly;
            logic [pDataWidth-1:0] rdStage2;

            // Second stage advances only on the cycle after a read was issued.
            always_ff @(posedge iCLK) begin
                if (!inARST) begin
                    reDly    <= 1'b0;
                    rdStage2 <= '0;
                end else begin
                    reDly <= iRe;
                    if (reDly) begin
                        rdStage2 <= rdStage1;
                    end
                end
            end

            assign oRd = rdStage2;
        end else begin : gOneStage
            assign oRd = rdStage1;
        end
    endgenerate

endmodule

// File: tb/tb_trion_sdp_bram.sv
// Directed bench: one-stage and two-stage instances driven in parallel with identical stimulus.
module tb_trion_sdp_bram;

    logic       iCLK = 1'b0;
    logic       inARST;
    logic [7:0] iWd;
    logic [8:0] iWa;
    logic       iWe;
    logic [8:0] iRa;
    logic       iRe;
    logic [7:0] rd1;
    logic [7:0] rd2;

    int assertCnt = 0;
    int failCnt   = 0;

    always #5 iCLK = ~iCLK;

    trion_sdp_bram #(.pDataWidth(8), .pAddrWidth(9), .pOutReg("no")) dut1 (
        .iCLK(iCLK), .inARST(inARST), .iWd(iWd), .iWa(iWa), .iWe(iWe),
        .iRa(iRa), .iRe(iRe), .oRd(rd1)
    );

    trion_sdp_bram #(.pDataWidth(8), .pAddrWidth(9), .pOutReg("yes")) dut2 (
        .iCLK(iCLK), .inARST(inARST), .iWd(iWd), .iWa(iWa), .iWe(iWe),
        .iRa(iRa), .iRe(iRe), .oRd(rd2)
    );

    task automatic cyc();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assertCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [8:0] a;
        logic [7:0] e;

        inARST = 1'b0; iWd = '0; iWa = '0; iWe = 1'b0; iRa = '0; iRe = 1'b0;

        // reset held for three edges, with a write attempt that must be ignored
        iWe = 1'b1; iWa = 9'd0; iWd = 8'h5A; iRe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("reset_rd1", rd1, 8'h00);
            chk("reset_rd2", rd2, 8'h00);
        end
        $display("reset held 3 edges: rd1=%h rd2=%h", rd1, rd2);

        // release and read power-up content of address 0
        inARST = 1'b1; iWe = 1'b0; iRe = 1'b1; iRa = 9'd0;
        cyc();
        chk("powerup_rd1", rd1, 8'h00);
        iRe = 1'b0;
        cyc();
        chk("powerup_rd2", rd2, 8'h00);
        $display("power-up read addr 0: rd1=%h rd2=%h", rd1, rd2);

        // write 0xA5 to 0x1F0, then read it back
        iWe = 1'b1; iWa = 9'h1F0; iWd = 8'hA5;
        cyc();
        iWe = 1'b0; iRe = 1'b1; iRa = 9'h1F0;
        cyc();
        chk("wr_rd_lat1", rd1, 8'hA5);
        chk("wr_rd_stage2_not_yet", rd2, 8'h00);
        iRe = 1'b0; iRa = 9'h000;
        cyc();
        chk("hold_rd1", rd1, 8'hA5);
        chk("wr_rd_lat2", rd2, 8'hA5);
        cyc();
        chk("hold_rd1_b", rd1, 8'hA5);
        chk("hold_rd2", rd2, 8'hA5);
        $display("write/read 0x1F0: rd1=%h rd2=%h", rd1, rd2);

        // read-first collision on address 5
        iWe = 1'b1; iWa = 9'd5; iWd = 8'h11;
        cyc();
        iWd = 8'h22; iRe = 1'b1; iRa = 9'd5;
        cyc();
        chk("collision_old", rd1, 8'h11);
        iWe = 1'b0;
        cyc();
        chk("collision_new", rd1, 8'h22);
        chk("collision_stage2", rd2, 8'h11);
        iRe = 1'b0;
        cyc();
        chk("collision_stage2_new", rd2, 8'h22);
        $display("collision addr 5: rd1=%h rd2=%h", rd1, rd2);

        // independent write to addr 7 while reading addr 5
        iWe = 1'b1; iWa = 9'd7; iWd = 8'h77; iRe = 1'b1; iRa = 9'd5;
        cyc();
        chk("indep_read", rd1, 8'h22);
        iWe = 1'b0; iRa = 9'd7;
        cyc();
        chk("indep_write", rd1, 8'h77);
        $display("independent ports: rd1=%h", rd1);

        // fill every address with its own index (low 8 bits)
        iRe = 1'b0; iWe = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a = 9'(i);
            iWa = a; iWd = a[7:0];
            cyc();
        end
        iWe = 1'b0;
        $display("filled 512 words");

        // sequential read burst
        iRe = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a = 9'(i);
            iRa = a;
            cyc();
            chk("burst_rd1", rd1, a[7:0]);
            if (i > 0) begin
                a = 9'(i - 1);
                chk("burst_rd2", rd2, a[7:0]);
            end
        end
        iRa = 9'd0;
        cyc();
        chk("burst_wrap", rd1, 8'h00);
        chk("burst_wrap_rd2", rd2, 8'hFF);
        $display("read burst 0..511 and wrap: rd1=%h rd2=%h", rd1, rd2);

        // reset mid-stream with a blocked write to addr 100
        for (int i = 0; i < 14; i++) begin
            a = 9'(i);
            iRa = a;
            if (i == 10) begin
                inARST = 1'b0; iWe = 1'b1; iWa = 9'd100; iWd = 8'hEE;
            end else begin
                inARST = 1'b1; iWe = 1'b0;
            end
            cyc();
            if (i == 10) begin
                chk("midrst_rd1", rd1, 8'h00);
                chk("midrst_rd2", rd2, 8'h00);
            end else if (i == 11) begin
                chk("post_rst_rd1", rd1, a[7:0]);
                chk("post_rst_rd2_held", rd2, 8'h00);
            end else begin
                chk("pre_post_rd1", rd1, a[7:0]);
            end
        end
        iRa = 9'd100;
        cyc();
        chk("preserved_100", rd1, 8'd100);
        e = 8'd13;
        chk("stage2_after_rst", rd2, e);
        iRe = 1'b0;
        cyc();
        chk("preserved_100_rd2", rd2, 8'd100);
        $display("reset mid-stream, addr 100: rd1=%h rd2=%h", rd1, rd2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
